gpi_periph: RTL and testbench
=============================

Name: gpi_periph

Overview:
- Memory-mapped general-purpose input peripheral: the read-side counterpart of the LED output peripheral on the CPU data bus.
- Samples external pins (buttons/switches) through a 2-flop synchronizer and a per-bit debounce counter.
- Latches sticky rising/falling edge flags (write-1-to-clear) and raises a maskable interrupt.
- The CPU reads state and flags through a registered 1-cycle read port; the top level ORs `data_out` into the data-memory read mux.

Parameters:
- N_INPUTS, 8, number of input pins; legal range 1..8.
- DEBOUNCE_CYCLES, 16, stable synchronized cycles required before the debounced state changes; legal range >= 2.

Ports:
- clk  input  1  system clock (the CPU clock).
- reset  input  1  synchronous, active-high reset.
- pins  input  N_INPUTS  asynchronous external inputs.
- sel  input  1  bus select for this peripheral, decoded at top level.
- address  input  10  byte address within the peripheral window.
- data_in  input  32  write data from the CPU.
- width  input  4  byte enables; bit0 enables data_in[7:0].
- write  input  1  write strobe.
- data_out  output  32  registered read data; 0 when not selected.
- irq  output  1  level interrupt request.

Behaviour:
- Register map (address[3:2]; address[9:4] must be 0, otherwise the access is unmapped):
  - 0x0 STATE (RO): debounced levels.
  - 0x4 RISE (W1C): sticky rising-edge flags.
  - 0x8 FALL (W1C): sticky falling-edge flags.
  - 0xC MASK (RW): interrupt enables.
  - Bits [31:N_INPUTS] read 0.
  - address[1:0] is ignored.
- Reset (synchronous, all state):
  - sync flops, debounced state, counters, RISE, FALL and MASK = 0.
  - data_out = 0, irq = 0.
- Synchronizer: sync1 <= pins; sync2 <= sync1.
- Debounce, per bit i:
  - If sync2[i] == state[i], cnt[i] <= 0.
  - Else if cnt[i] == DEBOUNCE_CYCLES-1, then state[i] <= sync2[i] and cnt[i] <= 0.
  - Else cnt[i] <= cnt[i]+1.
  - Counter width is clog2(DEBOUNCE_CYCLES).
  - A glitch shorter than DEBOUNCE_CYCLES synchronized cycles never changes state.
  - Latency: a pin change sampled at edge k appears in state after edge k+1+DEBOUNCE_CYCLES.
- Edge flags:
  - When state[i] goes 0->1, RISE[i] <= 1.
  - When state[i] goes 1->0, FALL[i] <= 1.
  - Flags stay set until cleared.
- Writes (sel && write, width[0]=1, mapped address):
  - RISE/FALL: bits where data_in[i]=1 are cleared. If an edge sets the same bit in the same cycle, set wins and the flag stays 1.
  - MASK <= data_in[N_INPUTS-1:0].
  - STATE writes are ignored.
  - width[0]=0: the write is ignored.
  - Unmapped writes are ignored.
- Reads:
  - When sel && !write, data_out <= selected register (zero-extended) on the next edge: 1-cycle latency, matching the memories.
  - Unmapped reads return 0.
  - When sel=0 or write=1, data_out <= 0.
  - Reads have no side effects.
- irq (registered): irq <= |((RISE | FALL) & MASK), i.e. it asserts 1 cycle after a flag or mask update.
- Reset mid-debounce discards all counts and flags; the next cycle behaves as if from power-up.

Test Plan:
- Reset: drive pins=8'hFF during reset, release reset. STATE reads 0 until edge 1+16 after sampling, then reads 8'hFF. RISE reads 8'hFF; FALL reads 0.
- Debounce glitch: pulse pins[2] high for 10 cycles, then low -> STATE, RISE and irq remain 0. Then hold pins[2] high for 20 cycles -> STATE=8'h04 exactly 17 edges after first sample; RISE=8'h04.
- W1C and simultaneous set: write RISE=8'h04 -> RISE reads 0. Then align a write of 8'h01 to RISE with the cycle state[0] rises -> RISE[0] reads 1.
- Interrupt masking:
  - MASK=0, create a FALL on bit 3 -> irq stays 0.
  - Write MASK=8'h08 -> irq=1 one cycle later.
  - Write FALL=8'h08 -> irq=0 one cycle later.
- Bus rules:
  - Read at 0x10 returns 0.
  - Write to STATE does not change it.
  - Write with width=4'b0010 to MASK leaves MASK unchanged.
  - data_out=0 whenever sel=0.
  - Read data appears exactly 1 cycle after the request.
- Reset mid-operation: assert reset while cnt[5]=8 and RISE=8'h20 -> next cycle cnt, RISE and irq = 0. Pin still high -> state[5] rises 17 edges later.

Source files
------------

// File: rtl/gpi_periph.sv
// -----------------------------------------------------------------------------
// gpi_periph
//
// Memory-mapped general-purpose input peripheral. External pins are passed
// through a two-flop synchronizer and a per-bit debounce counter. Sticky
// rising/falling edge flags (write-1-to-clear) drive a maskable, registered
// interrupt. The CPU reads registers through a 1-cycle registered read port
// that returns 0 whenever the peripheral is not being read.
//
// Register map (address[3:2], address[9:4] must be zero, address[1:0] ignored):
//   0x0 STATE (RO)  debounced pin levels
//   0x4 RISE  (W1C) sticky rising-edge flags
//   0x8 FALL  (W1C) sticky falling-edge flags
//   0xC MASK  (RW)  interrupt enables
//
// Ports:
//   clk       system clock
//   reset     synchronous, active-high reset
//   pins      asynchronous external inputs
//   sel       bus select for this peripheral
//   address   byte address within the peripheral window
//   data_in   CPU write data
//   width     byte enables (bit0 gates data_in[7:0])
//   write     write strobe
//   data_out  registered read data, 0 when not being read
//   irq       level interrupt request
// -----------------------------------------------------------------------------
module gpi_periph #(
    parameter int N_INPUTS        = 8,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_INPUTS-1:0] pins,
    input  logic                sel,
    input  logic [9:0]          address,
    input  logic [31:0]         data_in,
    input  logic [3:0]          width,
    input  logic                write,
    output logic [31:0]         data_out,
    output logic                irq
);

    localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [1:0] REG_STATE = 2'd0;
    localparam logic [1:0] REG_RISE  = 2'd1;
    localparam logic [1:0] REG_FALL  = 2'd2;
    localparam logic [1:0] REG_MASK  = 2'd3;

    logic [N_INPUTS-1:0] sync1_q, sync2_q;
    logic [N_INPUTS-1:0] state_q, state_d;
    logic [N_INPUTS-1:0] rise_q,  rise_d;
    logic [N_INPUTS-1:0] fall_q,  fall_d;
    logic [N_INPUTS-1:0] mask_q,  mask_d;
    logic [CNT_W-1:0]    cnt_q [N_INPUTS];
    logic [CNT_W-1:0]    cnt_d [N_INPUTS];
    logic [31:0]         data_out_q, data_out_d;
    logic                irq_q, irq_d;

    logic                mapped, wr_en, rd_en;
    logic [1:0]          reg_idx;
    logic [N_INPUTS-1:0] clr_rise, clr_fall, rd_val;
    logic                unused_bits;

    // Debounce: the counter runs only while the synchronized input disagrees
    // with the debounced level; any agreement restarts it, so only an
    // uninterrupted run of DEBOUNCE_CYCLES disagreeing samples flips the state.
    // NOTE: every combinationally assigned signal gets a default first so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        for (int i = 0; i < N_INPUTS; i++) begin
            if (sync2_q[i] == state_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                state_d[i] = sync2_q[i];
                cnt_d[i]   = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end
    end

    // Bus decode
    always_comb begin
        mapped  = (address[9:4] == 6'd0);
        reg_idx = address[3:2];
        wr_en   = sel & write & width[0] & mapped;
        rd_en   = sel & ~write & mapped;
    end

    // Flags: an edge detected this cycle is OR'd in after the clear, so a
    // simultaneous set wins over a write-1-to-clear.
    always_comb begin
        clr_rise = (wr_en && reg_idx == REG_RISE) ? data_in[N_INPUTS-1:0] : '0;
        clr_fall = (wr_en && reg_idx == REG_FALL) ? data_in[N_INPUTS-1:0] : '0;
        rise_d   = (rise_q & ~clr_rise) | (state_d & ~state_q);
        fall_d   = (fall_q & ~clr_fall) | (~state_d & state_q);
        mask_d   = (wr_en && reg_idx == REG_MASK) ? data_in[N_INPUTS-1:0] : mask_q;
        irq_d    = |((rise_q | fall_q) & mask_q);
    end

    // Read port: returns current register contents one edge after the request.
    always_comb begin
        rd_val = '0;
        case (reg_idx)
            REG_STATE: rd_val = state_q;
            REG_RISE:  rd_val = rise_q;
            REG_FALL:  rd_val = fall_q;
            REG_MASK:  rd_val = mask_q;
            default:   rd_val = '0;
        endcase
        data_out_d = rd_en ? 32'(rd_val) : 32'd0;
    end

    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every flop samples the pre-edge values regardless of block order.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            state_q    <= '0;
            rise_q     <= '0;
            fall_q     <= '0;
            mask_q     <= '0;
            data_out_q <= '0;
            irq_q      <= 1'b0;
            // NOTE: the counter array is real state (a reset mid-debounce must
            // discard partial counts), so each entry is cleared explicitly.
            for (int i = 0; i < N_INPUTS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q    <= pins;
            sync2_q    <= sync1_q;
            state_q    <= state_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            mask_q     <= mask_d;
            data_out_q <= data_out_d;
            irq_q      <= irq_d;
            cnt_q      <= cnt_d;
        end
    end

    assign data_out = data_out_q;
    assign irq      = irq_q;

    // Address byte offset, upper write data and upper byte enables carry no
    // meaning for this peripheral.
    assign unused_bits = ^{address[1:0], data_in[31:N_INPUTS], width[3:1]};

endmodule

// File: tb/tb_gpi_periph.sv
// -----------------------------------------------------------------------------
// tb_gpi_periph
//
// Self-checking bench for gpi_periph. A behavioural model predicts data_out
// and irq every cycle: the debounced level flips when the last
// DEBOUNCE_CYCLES synchronized samples (pins delayed two edges) all disagree
// with it. Directed sequences add literal expectations for reads and timing.
// -----------------------------------------------------------------------------
module tb_gpi_periph;

    localparam int N   = 8;
    localparam int DEB = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [N-1:0] pins;
    logic        sel;
    logic [9:0]  address;
    logic [31:0] data_in;
    logic [3:0]  width;
    logic        write;
    logic [31:0] data_out;
    logic        irq;

    gpi_periph #(
        .N_INPUTS        (N),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .pins     (pins),
        .sel      (sel),
        .address  (address),
        .data_in  (data_in),
        .width    (width),
        .write    (write),
        .data_out (data_out),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // hist[k] holds the pin sample taken k+1 edges before the current edge.
    logic [N-1:0] hist [0:DEB];
    logic [N-1:0] m_state = '0, m_rise = '0, m_fall = '0, m_mask = '0;
    logic [31:0]  m_dout = '0;
    logic         m_irq = 1'b0;
    bit           model_valid = 1'b0;

    always @(posedge clk) begin
        logic [N-1:0] nxt, clr_r, clr_f, rv;
        logic         all_opp, wr;
        if (reset) begin
            for (int k = 0; k <= DEB; k++) hist[k] = '0;
            m_state = '0; m_rise = '0; m_fall = '0; m_mask = '0;
            m_dout = '0; m_irq = 1'b0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            // Samples used at this edge were taken 2..DEB+1 edges ago.
            nxt = m_state;
            for (int b = 0; b < N; b++) begin
                all_opp = 1'b1;
                for (int k = 1; k <= DEB; k++)
                    if (hist[k][b] == m_state[b]) all_opp = 1'b0;
                if (all_opp) nxt[b] = ~m_state[b];
            end
            for (int k = DEB; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = pins;

            case (address[3:2])
                2'd0:    rv = m_state;
                2'd1:    rv = m_rise;
                2'd2:    rv = m_fall;
                default: rv = m_mask;
            endcase
            m_dout = (sel && !write && address[9:4] == 0) ? {24'd0, rv} : 32'd0;
            m_irq  = |((m_rise | m_fall) & m_mask);

            wr    = sel && write && width[0] && address[9:4] == 0;
            clr_r = (wr && address[3:2] == 2'd1) ? data_in[N-1:0] : '0;
            clr_f = (wr && address[3:2] == 2'd2) ? data_in[N-1:0] : '0;
            m_rise = (m_rise & ~clr_r) | (nxt & ~m_state);
            m_fall = (m_fall & ~clr_f) | (~nxt & m_state);
            if (wr && address[3:2] == 2'd3) m_mask = data_in[N-1:0];
            m_state = nxt;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (model_valid) begin
            check("cmp_data_out", data_out, m_dout);
            check("cmp_irq", {31'd0, irq}, {31'd0, m_irq});
        end
    end

    // ---------------- bus helpers (called right after a negedge) ----------------
    task automatic rd(input logic [9:0] a, output logic [31:0] d);
        sel = 1'b1; write = 1'b0; address = a;
        @(negedge clk);
        d = data_out;
        sel = 1'b0;
    endtask

    task automatic wr(input logic [9:0] a, input logic [31:0] d, input logic [3:0] w);
        sel = 1'b1; write = 1'b1; address = a; data_in = d; width = w;
        @(negedge clk);
        sel = 1'b0; write = 1'b0; width = 4'hF; data_in = '0;
    endtask

    // Holds a STATE read open and returns the negedge index at which the
    // expected value first appears (0 if it never does within the bound).
    task automatic state_latency(input string name, input logic [31:0] exp);
        int first;
        first = 0;
        sel = 1'b1; write = 1'b0; address = 10'h0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 10) check({name, "_early"}, data_out, 32'd0);
            if (first == 0 && data_out == exp) first = c;
        end
        sel = 1'b0;
        check({name, "_latency"}, first, 19);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] d;
        reset = 1'b1; pins = 8'hFF; sel = 1'b0; write = 1'b0;
        address = '0; data_in = '0; width = 4'hF;
        repeat (3) @(negedge clk);

        // Reset release with all pins high
        reset = 1'b0;
        state_latency("reset_state", 32'hFF);
        rd(10'h4, d); check("reset_rise", d, 32'hFF);
        rd(10'h8, d); check("reset_fall", d, 32'h00);

        // Fresh start with pins low, then a short glitch on bit 2
        pins = 8'h00; reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        pins[2] = 1'b1;
        repeat (10) @(negedge clk);
        pins[2] = 1'b0;
        repeat (25) @(negedge clk);
        rd(10'h0, d); check("glitch_state", d, 32'h00);
        rd(10'h4, d); check("glitch_rise", d, 32'h00);
        check("glitch_irq", {31'd0, irq}, 32'd0);

        // Sustained high on bit 2
        pins[2] = 1'b1;
        state_latency("bit2_state", 32'h04);
        rd(10'h4, d); check("bit2_rise", d, 32'h04);

        // W1C, then clear aligned with a new rise on bit 0
        wr(10'h4, 32'h04, 4'hF);
        rd(10'h4, d); check("w1c_rise", d, 32'h00);
        pins[0] = 1'b1;
        repeat (17) @(negedge clk);
        wr(10'h4, 32'h01, 4'hF);
        rd(10'h4, d); check("set_wins_rise", d, 32'h01);
        rd(10'h0, d); check("set_wins_state", d, 32'h05);

        // Masking: fall on bit 3 with MASK=0
        pins[3] = 1'b1;
        repeat (25) @(negedge clk);
        wr(10'h4, 32'hFF, 4'hF);
        pins[3] = 1'b0;
        repeat (25) @(negedge clk);
        rd(10'h8, d); check("bit3_fall", d, 32'h08);
        rd(10'h4, d); check("bit3_rise_cleared", d, 32'h00);
        check("masked_irq", {31'd0, irq}, 32'd0);
        wr(10'hC, 32'h08, 4'hF);
        check("mask_irq_t1", {31'd0, irq}, 32'd0);
        @(negedge clk);
        check("mask_irq_t2", {31'd0, irq}, 32'd1);
        wr(10'h8, 32'h08, 4'hF);
        check("clr_irq_t1", {31'd0, irq}, 32'd1);
        @(negedge clk);
        check("clr_irq_t2", {31'd0, irq}, 32'd0);

        // Bus rules
        rd(10'h10, d); check("unmapped_read", d, 32'h0);
        rd(10'h3, d);  check("byte_offset_read", d, 32'h05);
        wr(10'h0, 32'hFF, 4'hF);
        rd(10'h0, d);  check("state_ro", d, 32'h05);
        wr(10'hC, 32'hFF, 4'b0010);
        rd(10'hC, d);  check("width_gated", d, 32'h08);
        wr(10'h1C, 32'hFF, 4'hF);
        rd(10'hC, d);  check("unmapped_write", d, 32'h08);
        @(negedge clk);
        check("idle_zero", data_out, 32'h0);

        // Reset in the middle of a debounce count on bit 5
        wr(10'h4, 32'hFF, 4'hF);
        wr(10'h8, 32'hFF, 4'hF);
        pins[5] = 1'b1;
        repeat (25) @(negedge clk);
        rd(10'h4, d); check("bit5_rise", d, 32'h20);
        pins[5] = 1'b0;
        repeat (25) @(negedge clk);
        wr(10'h8, 32'hFF, 4'hF);
        wr(10'hC, 32'h20, 4'hF);
        @(negedge clk);
        check("bit5_irq", {31'd0, irq}, 32'd1);
        pins[5] = 1'b1;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_irq", {31'd0, irq}, 32'd0);
        check("midreset_dout", data_out, 32'h0);
        reset = 1'b0;
        state_latency("post_reset_state", 32'h25);
        rd(10'h4, d); check("post_reset_rise", d, 32'h25);
        rd(10'h8, d); check("post_reset_fall", d, 32'h00);
        check("post_reset_irq", {31'd0, irq}, 32'd0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
